// File: rtl/prefix_adder_pkg.sv
// Shared types and lane helpers for the segmented Kogge-Stone add/subtract pipeline.
// Lane geometry is derived from the per-transaction precision code.
package prefix_adder_pkg;

    typedef enum logic [1:0] {
        PREC_8    = 2'b00,
        PREC_16   = 2'b01,
        PREC_32   = 2'b10,
        PREC_FULL = 2'b11
    } prec_e;

    // Bit k set registers the output of prefix level k (level 0 = p/g generation).
    localparam logic [5:0] DefaultPipeMask = 6'b100101;

    // Upper bound on operand width for the fixed-width lane mask helper.
    localparam int unsigned MaxAdderWidth = 1024;

    function automatic int unsigned lane_width(prec_e prec, int unsigned width);
        unique case (prec)
            PREC_8:  return 8;
            PREC_16: return 16;
            PREC_32: return 32;
            default: return width;
        endcase
    endfunction

    function automatic logic [MaxAdderWidth-1:0] lane_lsb_mask(prec_e prec, int unsigned width);
        logic [MaxAdderWidth-1:0] mask;
        int unsigned lw;
        mask = '0;
        lw   = lane_width(prec, width);
        for (int unsigned i = 0; i < MaxAdderWidth; i++) begin
            if (i < width && (i & (lw - 1)) == 0) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Lanes are power-of-two aligned, so equal upper index bits means same lane.
    function automatic logic same_lane(int i, int k, prec_e prec);
        int sh;
        if (prec == PREC_FULL) begin
            return 1'b1;
        end
        sh = 3 + int'(prec);
        return (i >> sh) == (k >> sh);
    endfunction

endpackage

// File: rtl/prefix_pipe_stage.sv
// Valid/ready register slice with synchronous flush of the valid bit.
// Data is only captured on a handshake, so it is held while stalled.
module prefix_pipe_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_q;
    logic             data_en;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign data_en     = in_ready_o & in_valid_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (data_en) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined lane-segmented Kogge-Stone add/subtract with valid/ready flow control.
// A register slice follows every prefix level whose PIPE_MASK bit is set.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = 32,
    parameter logic [$clog2(ADDER_WIDTH):0] PIPE_MASK =
        ($clog2(ADDER_WIDTH) + 1)'(DefaultPipeMask)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ADDER_WIDTH-1:0]   operand_a_i,
    input  logic [ADDER_WIDTH-1:0]   operand_b_i,
    input  logic                     cin_i,
    input  logic                     sub_i,
    input  logic [1:0]               prec_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDER_WIDTH-1:0]   sum_o,
    output logic [ADDER_WIDTH/8-1:0] carry_o
);

    localparam int unsigned STAGE    = $clog2(ADDER_WIDTH);
    localparam int unsigned NumSlots = ADDER_WIDTH / 8;

    // Everything a transaction needs downstream travels together through each slice.
    typedef struct packed {
        logic [ADDER_WIDTH-1:0] g;
        logic [ADDER_WIDTH-1:0] p;
        logic [ADDER_WIDTH-1:0] p0;
        logic [ADDER_WIDTH-1:0] lsb;
        logic [1:0]             prec;
        logic                   cin;
    } bundle_t;

    localparam int unsigned BundleW = $bits(bundle_t);

    logic [ADDER_WIDTH-1:0]   b_eff, p_pre, lsb_pre;
    logic [MaxAdderWidth-1:0] lsb_full;
    logic                     cin_eff;
    bundle_t                  pre_d;

    assign b_eff    = operand_b_i ^ {ADDER_WIDTH{sub_i}};
    assign cin_eff  = cin_i ^ sub_i;
    assign lsb_full = lane_lsb_mask(prec_e'(prec_i), ADDER_WIDTH);
    assign lsb_pre  = lsb_full[ADDER_WIDTH-1:0];
    assign p_pre    = operand_a_i ^ b_eff;

    // Carry-in is folded into the generate of every lane LSB.
    assign pre_d = '{
        g:    (operand_a_i & b_eff) | (lsb_pre & p_pre & {ADDER_WIDTH{cin_eff}}),
        p:    p_pre,
        p0:   p_pre,
        lsb:  lsb_pre,
        prec: prec_i,
        cin:  cin_eff
    };

    if (ADDER_WIDTH < MaxAdderWidth) begin : g_unused_hi
        logic unused_lsb_hi;
        assign unused_lsb_hi = ^lsb_full[MaxAdderWidth-1:ADDER_WIDTH];
    end

    for (genvar k = 0; k <= STAGE; k++) begin : g_lvl
        bundle_t lvl_d, d_out;
        logic    v_in, v_out, r_in, r_out;

        if (k == 0) begin : g_pre
            assign v_in  = in_valid_i & ~flush_i;
            assign lvl_d = pre_d;
        end else begin : g_kogge
            localparam int Dist = 2 ** (k - 1);
            bundle_t din;

            assign v_in = g_lvl[k-1].v_out;
            assign din  = g_lvl[k-1].d_out;

            always_comb begin
                lvl_d = din;
                for (int i = Dist; i < int'(ADDER_WIDTH); i++) begin
                    if (same_lane(i, i - Dist, prec_e'(din.prec))) begin
                        lvl_d.g[i] = din.g[i] | (din.p[i] & din.g[i-Dist]);
                        lvl_d.p[i] = din.p[i] & din.p[i-Dist];
                    end
                end
            end
        end

        if (k == STAGE) begin : g_last
            assign r_in = out_ready_i;
        end else begin : g_mid
            assign r_in = g_lvl[k+1].r_out;
        end

        if (PIPE_MASK[k]) begin : g_reg
            prefix_pipe_stage #(
                .Width(BundleW)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush_i    (flush_i),
                .in_valid_i (v_in),
                .in_ready_o (r_out),
                .in_data_i  (lvl_d),
                .out_valid_o(v_out),
                .out_ready_i(r_in),
                .out_data_o (d_out)
            );
        end else begin : g_comb
            assign d_out = lvl_d;
            assign v_out = v_in;
            assign r_out = r_in;
        end
    end

    bundle_t                fin;
    logic [ADDER_WIDTH-1:0] carry_in;
    logic                   unused_fin;

    assign fin         = g_lvl[STAGE].d_out;
    assign out_valid_o = g_lvl[STAGE].v_out;
    assign in_ready_o  = g_lvl[0].r_out & ~flush_i;
    assign unused_fin  = ^{fin.p, fin.prec};

    always_comb begin
        carry_in    = '0;
        carry_in[0] = fin.cin;
        for (int i = 1; i < int'(ADDER_WIDTH); i++) begin
            carry_in[i] = fin.lsb[i] ? fin.cin : fin.g[i-1];
        end
    end

    assign sum_o = fin.p0 ^ carry_in;

    // A byte slot reports carry only when its MSB is also the MSB of its lane.
    always_comb begin
        carry_o = '0;
        for (int s = 0; s < int'(NumSlots) - 1; s++) begin
            if (fin.lsb[8*s+8]) begin
                carry_o[s] = fin.g[8*s+7];
            end
        end
        carry_o[NumSlots-1] = fin.g[ADDER_WIDTH-1];
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe with default 32-bit width and 3-cycle latency.
module tb_prefix_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic        cin_i = 1'b0;
    logic        sub_i = 1'b0;
    logic [1:0]  prec_i = 2'b00;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] sum_o;
    logic [3:0]  carry_o;

    int checks = 0;
    int failures = 0;
    int sent, recv;
    logic fire_in, fire_out;

    always #5 clk = ~clk;

    prefix_adder_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .cin_i      (cin_i),
        .sub_i      (sub_i),
        .prec_i     (prec_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .sum_o      (sum_o),
        .carry_o    (carry_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic [1:0] prec);
        operand_a_i = a;
        operand_b_i = b;
        cin_i       = cin;
        sub_i       = sub;
        prec_i      = prec;
        in_valid_i  = 1'b1;
    endtask

    // Single transaction through an otherwise idle pipe; result expected after 3 edges.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [1:0] prec,
                           input logic [31:0] exp_sum, input logic [3:0] exp_carry);
        drive(a, b, cin, sub, prec);
        #1;
        check({tag, "_in_ready"}, in_ready_o, 1);
        step();
        in_valid_i = 1'b0;
        check({tag, "_lat1"}, out_valid_o, 0);
        step();
        check({tag, "_lat2"}, out_valid_o, 0);
        step();
        check({tag, "_valid"}, out_valid_o, 1);
        check({tag, "_sum"}, sum_o, exp_sum);
        check({tag, "_carry"}, carry_o, exp_carry);
        step();
        check({tag, "_drained"}, out_valid_o, 0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_valid", out_valid_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_carry", carry_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        rst_n = 1'b1;
        step();

        run_vec("full_add", 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 2'b10, 32'h0000_0000, 4'b1000);
        run_vec("byte_add", 32'h80FF_7F01, 32'h8001_0101, 0, 0, 2'b00, 32'h0000_8002, 4'b1100);
        run_vec("half_sub", 32'h0005_0003, 32'h0006_0001, 0, 1, 2'b01, 32'hFFFF_0002, 4'b0010);
        run_vec("byte_cin", 32'h0000_00FF, 32'h0000_0000, 1, 0, 2'b00, 32'h0101_0100, 4'b0001);
        run_vec("half_add", 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 2'b01, 32'h7FFF_0000, 4'b0010);
        run_vec("wide_add", 32'h0000_FFFF, 32'h0000_0001, 0, 0, 2'b11, 32'h0001_0000, 4'b0000);
        run_vec("word_borrow", 32'h0000_0003, 32'h0000_0005, 0, 1, 2'b10, 32'hFFFF_FFFE, 4'b0000);
        run_vec("word_sub_bin", 32'h0000_0005, 32'h0000_0003, 1, 1, 2'b10, 32'h0000_0001, 4'b1000);

        // Reset in the middle of traffic
        out_ready_i = 1'b0;
        drive(32'h1111_1111, 32'h2222_2222, 0, 0, 2'b10);
        step();
        drive(32'h0000_0001, 32'h0000_0001, 0, 0, 2'b10);
        step();
        drive(32'h0000_0010, 32'h0000_0020, 0, 0, 2'b10);
        step();
        in_valid_i = 1'b0;
        check("rst_pre_valid", out_valid_o, 1);
        check("rst_pre_sum", sum_o, 32'h3333_3333);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid_o, 0);
        check("rst_mid_sum", sum_o, 0);
        check("rst_mid_carry", carry_o, 0);
        step();
        step();
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check("rst_rel_ready", in_ready_o, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_no_stale", out_valid_o, 0);
        end

        // Backpressure: 6 back-to-back inputs, sink stalled in cycles 2-8
        sent = 0;
        recv = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid_i  = (sent < 6);
            operand_a_i = sent;
            operand_b_i = 32'h0000_0100;
            cin_i       = 1'b0;
            sub_i       = 1'b0;
            prec_i      = 2'b10;
            out_ready_i = !(c >= 2 && c <= 8);
            #1;
            if (c == 2) check("bp_ready_c2", in_ready_o, 1);
            if (c >= 3 && c <= 8) begin
                check("bp_ready_stall", in_ready_o, 0);
                check("bp_hold_valid", out_valid_o, 1);
            end
            if (out_valid_o) begin
                if (recv < 6) check("bp_order", sum_o, 32'h0000_0100 + recv);
                else check("bp_extra", out_valid_o, 0);
            end
            fire_in  = in_valid_i && in_ready_o;
            fire_out = out_valid_o && out_ready_i;
            step();
            if (fire_in) sent++;
            if (fire_out) recv++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("bp_sent", sent, 6);
        check("bp_recv", recv, 6);

        // Flush with three in flight and a same-cycle input
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_00A0 + i, 32'h0, 0, 0, 2'b10);
            step();
        end
        drive(32'h0000_00A3, 32'h0, 0, 0, 2'b10);
        flush_i = 1'b1;
        #1;
        check("flush_in_ready", in_ready_o, 0);
        check("flush_out_valid", out_valid_o, 1);
        check("flush_out_sum", sum_o, 32'h0000_00A0);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("flush_cleared", out_valid_o, 0);
        run_vec("post_flush", 32'h0000_0055, 32'h0000_0011, 0, 0, 2'b10, 32'h0000_0066, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
Pipelined, lane-segmented Kogge-Stone add/subtract unit. It is the successor to the combinational prefix adder in the vector multiplier datapath.
- Register stages are placed per prefix level via a mask parameter.
- Carries are split into 8/16/32-bit SIMD lanes per transaction (precision 00/01/10).
- Supports per-transaction carry-in and subtract.
- Uses a valid/ready handshake so it can sit between the partial-product reduction stage and the result formatter.

Parameters:
- ADDER_WIDTH, 32, operand width; must be a multiple of 32 and at least 32.
- STAGE, $clog2(ADDER_WIDTH), number of prefix levels; derived, not to be overridden.
- PIPE_MASK, 6'b100101, STAGE+1 bits. Bit k=1 inserts a register after level k (level 0 = pre-processing p/g). Latency is LAT = popcount(PIPE_MASK), and LAT must be at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous pipeline clear
- in_valid_i  in  1  input transaction valid
- in_ready_o  out  1  block can accept
- operand_a_i  in  ADDER_WIDTH  operand A
- operand_b_i  in  ADDER_WIDTH  operand B
- cin_i  in  1  carry-in, applied to every lane LSB
- sub_i  in  1  1 = A - B - borrow
- prec_i  in  2  00 = 8-bit lanes, 01 = 16-bit, 10 = 32-bit, 11 = single full-width lane
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- sum_o  out  ADDER_WIDTH  lane sums
- carry_o  out  ADDER_WIDTH/8  per-byte-slot carry-out

Behaviour:
- Reset: clk and reset are one clock domain; reset is asynchronous, active-low (rst_n). Every stage valid bit and every data/prec register clears to 0. Outputs are out_valid_o=0, sum_o=0, carry_o=0, in_ready_o=1. Reset asserted mid-operation discards all in-flight transactions with no output.
- Operand conditioning: b_eff = operand_b_i XOR {ADDER_WIDTH{sub_i}}; cin_eff = cin_i XOR sub_i.
- Pre-processing: p = a ^ b_eff, g = a & b_eff. At every lane LSB bit, g' = g | (p & cin_eff).
- Segmentation: at level j, bit i combines with bit i-2^(j-1) only if both bits are in the same lane; otherwise it passes g/p through unchanged. Lane width is 8/16/32/ADDER_WIDTH per prec.
- Sum: sum[i] = p0[i] ^ carry-into-i, where carry into a lane LSB is cin_eff.
- carry_o[k] = final group generate of byte slot k's MSB bit, when slot k is the MSB slot of its lane; otherwise 0. For sub_i=1, carry_o=1 means no borrow.
- prec_i and lane masks travel with the data through every register stage; no cross-transaction mixing is allowed.
- Pipeline handshake: each register stage has a valid bit.
  - Stage s loads when valid[s]=0 or stage s+1 accepts. The last stage accepts when out_ready_i=1.
  - Bubble-collapsing; ready is computed combinationally from the output back.
  - in_ready_o = stage-1 accept AND NOT flush_i.
  - Throughput is 1 per cycle with no backpressure. Latency is exactly LAT cycles from accepted input to out_valid_o.
  - Capacity is LAT transactions.
- Output stability: while out_valid_o=1 and out_ready_i=0, sum_o and carry_o are held stable.
- flush_i: all valid bits clear on the next edge. Flush has priority over a same-cycle input, and that input is not accepted (in_ready_o=0). A same-cycle output handshake still completes.
- Data registers are not cleared by flush. out_valid_o=0 masks their contents.
- Result ordering equals acceptance order.

Decomposition:
- Package prefix_adder_pkg:
  - prec_e enum (PREC_8, PREC_16, PREC_32, PREC_FULL)
  - function lane_lsb_mask(prec, width)
  - function same_lane(i, k, prec)
  - localparam for the default PIPE_MASK
- Reuse the existing pre/black/grey/sum cells for the datapath.
- One sub-module, prefix_pipe_stage: a parameterised-width valid/ready register slice with flush, instantiated where PIPE_MASK bit = 1.

Test Plan:
- Reset: drive 3 transactions, assert rst_n low for 2 cycles mid-stream -> out_valid_o=0, sum_o=0, carry_o=0 immediately; in_ready_o=1 after release; no stale outputs.
- Full-width add: a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0, prec=10 -> after 3 cycles sum_o=0x0000_0000, carry_o=4'b1000.
- Byte lanes: a=0x80FF_7F01, b=0x8001_0101, prec=00 -> sum_o=0x0000_8002, carry_o=4'b1100 (no carry crosses lanes).
- Halfword subtract: a=0x0005_0003, b=0x0006_0001, sub=1, cin=0, prec=01 -> sum_o=0xFFFF_0002, carry_o=4'b0010.
- Backpressure: 6 back-to-back inputs with out_ready_i=0 for cycles 2-8 -> in_ready_o drops after 3 held; outputs stable while stalled; all 6 emerge in order, none lost or duplicated.
- Flush: 3 in flight, flush_i=1 together with in_valid_i=1 -> next cycle out_valid_o=0, the flush-cycle input is not accepted, and a subsequent input emerges after exactly 3 cycles.
